game_round_sequencer: RTL

- Top-level round/game controller that sequences the collisions ball datapath. It owns the active-high synchronous ball reset into collisions, the serve delay before each ball, life counting on each loss, ball-speed escalation via the line_drawer switch bus, and high/total score bookkeeping.
- It sits between the N8 controller start button and the collisions instance in the top level.
- Paddle logic uses play_en.
- Score displays read high_score and total_score.

---
 rtl/game_round_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/game_round_sequencer.sv
// Round/game controller for the collisions ball datapath: serve delay, lives, speed and scores.
// Latency: Moore outputs decode the state register; counters and scores update one edge after the event.
// Backpressure: none; start is edge-detected, lose is level-sampled, and the block never stalls.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   start        start button level (rising edge detected internally)
//   lose         collisions lose flag, sticky until ball_reset
//   score        collisions current-round hit count
//   ball_reset   active-high reset into collisions (high whenever not in PLAY)
//   sw_speed     ball speed select into collisions, 0 = slowest
//   play_en      paddle movement enable
//   lives        balls remaining in the current game
//   high_score   best single-round score since reset
//   total_score  sum of round scores this game, saturating at 1023
//   game_over    high while in GAME_OVER
//   state_o      debug state code: IDLE=0 SERVE=1 PLAY=2 MISS=3 GAME_OVER=4
module game_round_sequencer #(
  parameter int LIVES       = 3,
  parameter int SERVE_DELAY = 50000000,
  parameter int SPEED_STEP  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       lose,
  input  logic [7:0] score,
  output logic       ball_reset,
  output logic [1:0] sw_speed,
  output logic       play_en,
  output logic [2:0] lives,
  output logic [7:0] high_score,
  output logic [9:0] total_score,
  output logic       game_over,
  output logic [2:0] state_o
);

  localparam int              CNT_W      = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SERVE_DELAY - 1);
  localparam logic [2:0]      LIVES_INIT = 3'(LIVES);

  // Speed thresholds kept 32 bits wide so large SPEED_STEP values cannot wrap.
  localparam logic [31:0] TH1 = 32'(SPEED_STEP);
  localparam logic [31:0] TH2 = 32'(2 * SPEED_STEP);
  localparam logic [31:0] TH3 = 32'(3 * SPEED_STEP);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       lives_q, lives_d;
  logic [7:0]       high_q, high_d;
  logic [9:0]       total_q, total_d;
  logic [1:0]       speed_q, speed_d;
  logic             start_q, start_d;

  logic             start_rise;
  logic [10:0]      total_sum;
  logic [9:0]       total_sat;
  logic [31:0]      score_ext;
  logic [1:0]       speed_lvl;

  always_comb begin
    start_rise = start & ~start_q;
    start_d    = start;

    // One extra bit catches overflow past 1023.
    total_sum = {1'b0, total_q} + {3'b000, score};
    total_sat = total_sum[10] ? 10'h3FF : total_sum[9:0];

    score_ext = {24'd0, score};
    if (score_ext < TH1) begin
      speed_lvl = 2'd0;
    end else if (score_ext < TH2) begin
      speed_lvl = 2'd1;
    end else if (score_ext < TH3) begin
      speed_lvl = 2'd2;
    end else begin
      speed_lvl = 2'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    high_d  = high_q;
    total_d = total_q;
    speed_d = speed_q;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d = ST_SERVE;
          cnt_d   = CNT_LOAD;
          lives_d = LIVES_INIT;
          total_d = '0;
          speed_d = '0;
        end
      end

      ST_SERVE: begin
        // Loaded with SERVE_DELAY-1, so SERVE lasts exactly SERVE_DELAY cycles.
        if (cnt_q == '0) begin
          state_d = ST_PLAY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_PLAY: begin
        speed_d = speed_lvl;
        // start is deliberately not looked at here, so lose always wins.
        if (lose) begin
          state_d = ST_MISS;
        end
      end

      ST_MISS: begin
        // collisions clears score on this same edge, so score is still the round value.
        total_d = total_sat;
        if (score > high_q) begin
          high_d = score;
        end
        lives_d = lives_q - 3'd1;
        speed_d = '0;
        if (lives_q == 3'd1) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_SERVE;
          cnt_d   = CNT_LOAD;
        end
      end

      ST_OVER: begin
        if (start_rise) begin
          state_d = ST_SERVE;
          cnt_d   = CNT_LOAD;
          lives_d = LIVES_INIT;
          total_d = '0;
          speed_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lives_q <= LIVES_INIT;
      high_q  <= '0;
      total_q <= '0;
      speed_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lives_q <= lives_d;
      high_q  <= high_d;
      total_q <= total_d;
      speed_q <= speed_d;
      start_q <= start_d;
    end
  end

  // Decoded from the state register only, so reset drives ball_reset high immediately.
  assign ball_reset  = (state_q != ST_PLAY);
  assign play_en     = (state_q == ST_PLAY);
  assign game_over   = (state_q == ST_OVER);
  assign state_o     = state_q;
  assign sw_speed    = speed_q;
  assign lives       = lives_q;
  assign high_score  = high_q;
  assign total_score = total_q;

endmodule
